// File: rtl/monitor_sequencer_if.sv
// monitor_sequencer_if
// Groups the sequencer's control and handshake signals so that they travel
// between the sequencer and the sensor/activation side as a single bundle.
//   enable          : sequencer run enable (synchronised upstream)
//   data_valid      : sensor/ADC data ready, acknowledges sample_req
//   peligro         : combinational danger indication from the activation logic
//   sample_req      : sample request level, held until data_valid or timeout
//   alert_eval      : one-cycle strobe, alert-flag generator latches Alerta[1:0]
//   activar_decidir : one-cycle register-enable strobe for the activation logic
//   fast_mode       : fast polling period in use
//   sensor_fault    : sticky, a sample request timed out
//   cycle_count     : number of completed decisions, wraps at 8 bits
// master = the sequencer side, slave = the sensor/activation side.
interface monitor_sequencer_if;
  logic       enable;
  logic       data_valid;
  logic       peligro;
  logic       sample_req;
  logic       alert_eval;
  logic       activar_decidir;
  logic       fast_mode;
  logic       sensor_fault;
  logic [7:0] cycle_count;

  modport master (
    input  enable, data_valid, peligro,
    output sample_req, alert_eval, activar_decidir, fast_mode, sensor_fault, cycle_count
  );

  modport slave (
    output enable, data_valid, peligro,
    input  sample_req, alert_eval, activar_decidir, fast_mode, sensor_fault, cycle_count
  );
endinterface

// File: rtl/monitor_sequencer.sv
// monitor_sequencer
// Periodic sequencer for the cabin gas-monitoring path. Each period it waits
// SLOW_DIV (or FAST_DIV) cycles, raises sample_req until data_valid or
// TIMEOUT, strobes alert_eval, then strobes activar_decidir so the activation
// logic registers new Alarma/Ventilacion values. peligro, sampled on the
// decide cycle, switches to fast polling; CALM_CYCLES calm decisions in a row
// return to slow polling. A timed-out request sets the sticky sensor_fault.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : monitor_sequencer_if.master (enable, data_valid, peligro in;
//         sample_req, alert_eval, activar_decidir, fast_mode, sensor_fault,
//         cycle_count out). Every output comes straight from a flop.
module monitor_sequencer #(
  parameter int SLOW_DIV    = 1000,
  parameter int FAST_DIV    = 250,
  parameter int TIMEOUT     = 64,
  parameter int CALM_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  monitor_sequencer_if.master   bus
);

  localparam int PW = $clog2(SLOW_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CALM_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    REQUEST   = 3'd2,
    EVALUATE  = 3'd3,
    DECIDE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   period_q, period_d;
  logic [TW-1:0]   timeout_q, timeout_d;
  logic [CW-1:0]   calm_q, calm_d;
  logic            fast_mode_q, fast_mode_d;
  logic            sensor_fault_q, sensor_fault_d;
  logic [7:0]      cycle_count_q, cycle_count_d;
  logic            sample_req_q, sample_req_d;
  logic            alert_eval_q, alert_eval_d;
  logic            activar_decidir_q, activar_decidir_d;

  // Period length loaded on every entry into WAIT_TICK.
  function automatic logic [PW-1:0] period_load(input logic fast);
    if (fast) begin
      return PW'(FAST_DIV);
    end else begin
      return PW'(SLOW_DIV);
    end
  endfunction

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    timeout_d      = timeout_q;
    calm_d         = calm_q;
    fast_mode_d    = fast_mode_q;
    sensor_fault_d = sensor_fault_q;
    cycle_count_d  = cycle_count_q;

    if (!bus.enable && (state_q != IDLE)) begin
      // Abort: any in-flight request is dropped without a decision.
      state_d        = IDLE;
      period_d       = '0;
      timeout_d      = '0;
      calm_d         = '0;
      fast_mode_d    = 1'b0;
      sensor_fault_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable) begin
            state_d  = WAIT_TICK;
            period_d = period_load(fast_mode_q);
          end else begin
            state_d  = IDLE;
          end
        end
        WAIT_TICK: begin
          // Counter runs DIV..1, so WAIT_TICK lasts exactly DIV cycles.
          if (period_q <= PW'(1)) begin
            state_d   = REQUEST;
            timeout_d = '0;
          end else begin
            period_d  = period_q - PW'(1);
          end
        end
        REQUEST: begin
          // data_valid wins over a timeout expiring in the same cycle.
          if (bus.data_valid) begin
            state_d = EVALUATE;
          end else if (timeout_q == TW'(TIMEOUT - 1)) begin
            state_d        = WAIT_TICK;
            sensor_fault_d = 1'b1;
            period_d       = period_load(fast_mode_q);
          end else begin
            timeout_d = timeout_q + TW'(1);
          end
        end
        EVALUATE: begin
          state_d = DECIDE;
        end
        DECIDE: begin
          cycle_count_d = cycle_count_q + 8'd1;
          if (bus.peligro) begin
            fast_mode_d = 1'b1;
            calm_d      = '0;
          end else if (fast_mode_q) begin
            if (calm_q == CW'(CALM_CYCLES - 1)) begin
              fast_mode_d = 1'b0;
              calm_d      = '0;
            end else begin
              calm_d      = calm_q + CW'(1);
            end
          end else begin
            fast_mode_d = fast_mode_q;
            calm_d      = calm_q;
          end
          // The period right after a decision already uses the new mode.
          state_d  = WAIT_TICK;
          period_d = period_load(fast_mode_d);
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from the next state so they appear as flop outputs.
  always_comb begin
    sample_req_d      = (state_d == REQUEST);
    alert_eval_d      = (state_d == EVALUATE);
    activar_decidir_d = (state_d == DECIDE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      period_q          <= '0;
      timeout_q         <= '0;
      calm_q            <= '0;
      fast_mode_q       <= 1'b0;
      sensor_fault_q    <= 1'b0;
      cycle_count_q     <= 8'd0;
      sample_req_q      <= 1'b0;
      alert_eval_q      <= 1'b0;
      activar_decidir_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      period_q          <= period_d;
      timeout_q         <= timeout_d;
      calm_q            <= calm_d;
      fast_mode_q       <= fast_mode_d;
      sensor_fault_q    <= sensor_fault_d;
      cycle_count_q     <= cycle_count_d;
      sample_req_q      <= sample_req_d;
      alert_eval_q      <= alert_eval_d;
      activar_decidir_q <= activar_decidir_d;
    end
  end

  assign bus.sample_req      = sample_req_q;
  assign bus.alert_eval      = alert_eval_q;
  assign bus.activar_decidir = activar_decidir_q;
  assign bus.fast_mode       = fast_mode_q;
  assign bus.sensor_fault    = sensor_fault_q;
  assign bus.cycle_count     = cycle_count_q;

endmodule
